cache_control: RTL

- Sequencing FSM for the 2-way, 8-set, 128-bit-line LC3b cache datapath.
- Takes CPU word requests and drives every array load enable, mux select and the LRU/valid/dirty write values of the datapath.
- Runs write-back and line-fill handshakes with physical memory.
- Sits between the CPU memory port and the datapath / physical memory port.

---
 rtl/cache_control_if.sv | 70 +++++++
 rtl/cache_control.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/cache_control_if.sv
// ============================================================================
// Module   : cache_control_if
// Brief    : Bundle of CPU, datapath and physical-memory signals around the
//            cache controller. Perf-counter signals exist with CACHE_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface cache_control_if
`ifdef CACHE_PERF_CNT_EN
    #(parameter int CNT_WIDTH = 16)
`endif
    ;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [2:0]  word_offset;
    logic        mem_resp;

    logic        hitA, hitB, lru_out;
    logic        valid_bit_A, valid_bit_B, dirty_bit_A, dirty_bit_B;

    logic        loadLRU;
    logic        loadValidBitArrayA, loadValidBitArrayB;
    logic        loadTagArrayA, loadTagArrayB;
    logic        loadDirtyBitArrayA, loadDirtyBitArrayB;
    logic        loadDataArrayA, loadDataArrayB;
    logic        valid_bit, dirty_bit, lru_bit;
    logic        array_sel, mem_address_sel, cache_in_sel;
    logic [15:0] sel_signal;

    logic        pmem_resp;
    logic        pmem_read, pmem_write;

`ifdef CACHE_PERF_CNT_EN
    logic                 perf_clear;
    logic [CNT_WIDTH-1:0] hit_count, miss_count;
`endif

    // master: the CPU / datapath / memory environment around the controller
    modport master (
        output mem_read, mem_write, mem_byte_enable, word_offset,
        output hitA, hitB, lru_out, valid_bit_A, valid_bit_B, dirty_bit_A, dirty_bit_B,
        output pmem_resp,
        input  mem_resp, loadLRU, loadValidBitArrayA, loadValidBitArrayB,
        input  loadTagArrayA, loadTagArrayB, loadDirtyBitArrayA, loadDirtyBitArrayB,
        input  loadDataArrayA, loadDataArrayB, valid_bit, dirty_bit, lru_bit,
        input  array_sel, mem_address_sel, cache_in_sel, sel_signal,
        input  pmem_read, pmem_write
`ifdef CACHE_PERF_CNT_EN
        , output perf_clear, input hit_count, miss_count
`endif
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, word_offset,
        input  hitA, hitB, lru_out, valid_bit_A, valid_bit_B, dirty_bit_A, dirty_bit_B,
        input  pmem_resp,
        output mem_resp, loadLRU, loadValidBitArrayA, loadValidBitArrayB,
        output loadTagArrayA, loadTagArrayB, loadDirtyBitArrayA, loadDirtyBitArrayB,
        output loadDataArrayA, loadDataArrayB, valid_bit, dirty_bit, lru_bit,
        output array_sel, mem_address_sel, cache_in_sel, sel_signal,
        output pmem_read, pmem_write
`ifdef CACHE_PERF_CNT_EN
        , input perf_clear, output hit_count, miss_count
`endif
    );
endinterface

`default_nettype wire

// File: rtl/cache_control.sv
// ============================================================================
// Module   : cache_control
// Brief    : IDLE/WRITEBACK/ALLOCATE sequencer for the 2-way LC3b cache.
//            Optional hit/miss counters enabled by macro CACHE_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cache_control #(
    parameter int CNT_WIDTH = 16
) (
    input  wire logic       clk,
    input  wire logic       reset,
    cache_control_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } state_t;

    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("cache_control: CNT_WIDTH must be at least 1");
    end

    state_t      r_state;
    logic        r_victim;

    logic        w_req, w_hit, w_hit_way, w_hit_resp, w_miss, w_victim_dirty;
    logic [15:0] w_sel;

    assign w_req          = bus.mem_read | bus.mem_write;
    assign w_hit          = bus.hitA | bus.hitB;
    // A double hit is illegal; resolving it toward way A keeps the mux deterministic.
    assign w_hit_way      = bus.hitB & ~bus.hitA;
    assign w_hit_resp     = (r_state == S_IDLE) & w_req & w_hit;
    assign w_miss         = (r_state == S_IDLE) & w_req & ~w_hit;
    assign w_victim_dirty = bus.lru_out ? (bus.valid_bit_B & bus.dirty_bit_B)
                                        : (bus.valid_bit_A & bus.dirty_bit_A);
    assign w_sel          = 16'(bus.mem_byte_enable) << {bus.word_offset, 1'b0};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_victim <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_victim <= bus.lru_out;
                        r_state  <= w_victim_dirty ? S_WRITEBACK : S_ALLOCATE;
                    end
                end
                S_WRITEBACK: if (bus.pmem_resp) r_state <= S_ALLOCATE;
                S_ALLOCATE:  if (bus.pmem_resp) r_state <= S_IDLE;
                default:     r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.mem_resp           = 1'b0;
        bus.loadLRU            = 1'b0;
        bus.loadValidBitArrayA = 1'b0;
        bus.loadValidBitArrayB = 1'b0;
        bus.loadTagArrayA      = 1'b0;
        bus.loadTagArrayB      = 1'b0;
        bus.loadDirtyBitArrayA = 1'b0;
        bus.loadDirtyBitArrayB = 1'b0;
        bus.loadDataArrayA     = 1'b0;
        bus.loadDataArrayB     = 1'b0;
        bus.valid_bit          = 1'b0;
        bus.dirty_bit          = 1'b0;
        bus.lru_bit            = 1'b0;
        bus.array_sel          = 1'b0;
        bus.mem_address_sel    = 1'b0;
        bus.cache_in_sel       = 1'b0;
        bus.sel_signal         = 16'h0000;
        bus.pmem_read          = 1'b0;
        bus.pmem_write         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hit_resp) begin
                    bus.mem_resp  = 1'b1;
                    bus.array_sel = w_hit_way;
                    bus.loadLRU   = 1'b1;
                    bus.lru_bit   = ~w_hit_way;
                    if (bus.mem_write) begin
                        bus.cache_in_sel       = 1'b1;
                        bus.dirty_bit          = 1'b1;
                        bus.sel_signal         = w_sel;
                        bus.loadDataArrayA     = ~w_hit_way;
                        bus.loadDataArrayB     = w_hit_way;
                        bus.loadDirtyBitArrayA = ~w_hit_way;
                        bus.loadDirtyBitArrayB = w_hit_way;
                    end
                end
            end
            S_WRITEBACK: begin
                bus.array_sel       = r_victim;
                bus.mem_address_sel = 1'b1;
                bus.pmem_write      = 1'b1;
            end
            S_ALLOCATE: begin
                bus.array_sel = r_victim;
                bus.pmem_read = 1'b1;
                if (bus.pmem_resp) begin
                    bus.valid_bit          = 1'b1;
                    bus.loadDataArrayA     = ~r_victim;
                    bus.loadDataArrayB     = r_victim;
                    bus.loadTagArrayA      = ~r_victim;
                    bus.loadTagArrayB      = r_victim;
                    bus.loadValidBitArrayA = ~r_victim;
                    bus.loadValidBitArrayB = r_victim;
                    bus.loadDirtyBitArrayA = ~r_victim;
                    bus.loadDirtyBitArrayB = r_victim;
                end
            end
            default: ;
        endcase
    end

`ifdef CACHE_PERF_CNT_EN
    logic                 r_after_fill;
    logic [CNT_WIDTH-1:0] r_hit_count, r_miss_count;

    // The response that completes a miss is not a hit and must not be counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_after_fill <= 1'b0;
        end else begin
            r_after_fill <= (r_state == S_ALLOCATE) & bus.pmem_resp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.perf_clear) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit_resp && !r_after_fill && (r_hit_count != '1))
                r_hit_count <= r_hit_count + 1'b1;
            if (w_miss && (r_miss_count != '1))
                r_miss_count <= r_miss_count + 1'b1;
        end
    end

    assign bus.hit_count  = r_hit_count;
    assign bus.miss_count = r_miss_count;
`endif
endmodule

`default_nettype wire
